uart_line_rx: RTL and testbench

Parametrised, synthesizable UART receiver with a line-buffering RX FIFO. It succeeds the bench-only UART decoder used in the CoreMark testbench: data width, parity mode, stop-bit count, baud rate and buffer depth are configurable, and it reports framing, parity and overflow errors. It sits behind the top-level `uart_txd_in` pin and feeds received bytes and an end-of-line indication to the core's memory-mapped UART peripheral and to bench monitors.

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/uart_rx_fifo.sv | 55 +++++
 rtl/uart_line_rx.sv | 206 ++++++++++++++++++++
 tb/tb_uart_line_rx.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and defaults for the UART receive path.
package riscv_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_rx_state_e;

    localparam int unsigned UART_BAUDRATE = 115_200;

    // Clock cycles per bit, rounded to nearest.
    function automatic int unsigned uart_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO with level output. A pop is only honoured when the FIFO
// holds data, and a push into a full FIFO is only honoured alongside a pop.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     wr_acc,
    output logic                     rd_acc
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign rd_acc  = rd_en && !empty;
    assign wr_acc  = wr_en && (!full || rd_acc);
    assign rd_data = mem[rd_ptr];
    assign level   = count;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            if (wr_acc && !rd_acc)
                count <= count + 1'b1;
            else if (!wr_acc && rd_acc)
                count <= count - 1'b1;
        end
    end

    // Storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_line_rx.sv
// UART receiver with sticky error flags, RX FIFO and end-of-line tracking.
module uart_line_rx import riscv_pkg::*; #(
    parameter int unsigned CLK_FREQ_HZ = 70_000_000,
    parameter int unsigned BAUDRATE    = UART_BAUDRATE,
    parameter int unsigned DATA_BITS   = 8,
    parameter parity_e     PARITY      = PAR_EVEN,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter logic [7:0]  EOL_CHAR    = 8'h0A
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          uart_rxd,
    output logic [7:0]                    m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          line_avail,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow,
    input  logic                          clr_err,
    output logic                          rx_busy
);

    localparam int unsigned DIV = uart_div(CLK_FREQ_HZ, BAUDRATE);
    localparam int CW = $clog2(DIV);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] HALF_LD = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LD = CW'(DIV - 1);

    if (DIV < 4) begin : g_div_chk
        $error("uart_line_rx: fewer than 4 clocks per bit");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bits_chk
        $error("uart_line_rx: DATA_BITS must be 5..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
        $error("uart_line_rx: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("uart_line_rx: FIFO_DEPTH must be a power of two >= 2");
    end

    logic                 rxd_m, rxd_s;
    uart_rx_state_e       state;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 armed;
    logic                 bad_par, bad_stop;
    logic                 push_q, par_hit, frm_hit;
    logic                 tick, exp_par;
    logic [7:0]           rx_byte;
    logic                 fifo_full, fifo_empty, wr_acc, rd_acc, drop;
    logic                 eol_in, eol_out;
    logic [LW-1:0]        eol_cnt;

    assign tick    = (cnt == '0);
    assign exp_par = (PARITY == PAR_ODD) ? ~^shreg : ^shreg;
    assign rx_byte = 8'(shreg);
    assign rx_busy = (state != ST_IDLE);

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= uart_rxd;
            rxd_s <= rxd_m;
        end
    end

    // Frame FSM. 'armed' requires the line to be seen high in IDLE before a
    // falling level counts as a start, so a held-low break is not re-read.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            armed    <= 1'b0;
            bad_par  <= 1'b0;
            bad_stop <= 1'b0;
            push_q   <= 1'b0;
            par_hit  <= 1'b0;
            frm_hit  <= 1'b0;
        end else begin
            push_q  <= 1'b0;
            par_hit <= 1'b0;
            frm_hit <= 1'b0;
            if (state != ST_IDLE && !tick) cnt <= cnt - 1'b1;
            case (state)
                ST_IDLE: begin
                    if (rxd_s) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        armed <= 1'b0;
                        state <= ST_START;
                        cnt   <= HALF_LD;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (rxd_s) begin
                            state <= ST_IDLE;
                        end else begin
                            state    <= ST_DATA;
                            cnt      <= FULL_LD;
                            bit_cnt  <= '0;
                            bad_par  <= 1'b0;
                            bad_stop <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
                        cnt   <= FULL_LD;
                        if (bit_cnt == 4'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            state   <= (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        cnt   <= FULL_LD;
                        state <= ST_STOP;
                        if (rxd_s != exp_par) begin
                            bad_par <= 1'b1;
                            par_hit <= 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        cnt <= FULL_LD;
                        if (!rxd_s) begin
                            bad_stop <= 1'b1;
                            frm_hit  <= 1'b1;
                        end
                        if (bit_cnt == 4'(STOP_BITS - 1)) begin
                            state  <= ST_IDLE;
                            push_q <= !bad_par && !bad_stop && rxd_s;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .wr_en   (push_q),
        .wr_data (rx_byte),
        .rd_en   (m_ready),
        .rd_data (m_data),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .wr_acc  (wr_acc),
        .rd_acc  (rd_acc)
    );

    assign m_valid = !fifo_empty;
    assign drop    = push_q && fifo_full && !rd_acc;
    assign eol_in  = wr_acc && (rx_byte == EOL_CHAR);
    assign eol_out = rd_acc && (m_data == EOL_CHAR);

    // Count of EOL bytes currently buffered.
    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            eol_cnt <= '0;
        else if (eol_in && !eol_out)
            eol_cnt <= eol_cnt + 1'b1;
        else if (!eol_in && eol_out)
            eol_cnt <= eol_cnt - 1'b1;
    end

    assign line_avail = (eol_cnt != '0);

    // Sticky error flags; a clear wins over a same-cycle set.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || clr_err) begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (par_hit) parity_err <= 1'b1;
            if (frm_hit) frame_err  <= 1'b1;
            if (drop)    overflow   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_line_rx.sv
// Bench for uart_line_rx: dut_a is 8E1 with a 4-deep FIFO, dut_b is 7O2
// with a 16-deep FIFO; both run at 16 clocks per bit.
module tb_uart_line_rx;
    import riscv_pkg::*;

    localparam int DIV = 16;

    logic       sys_clk = 1'b0;
    logic       rst_a = 1'b1, rst_b = 1'b1;
    logic       rxd_a = 1'b1, rxd_b = 1'b1;
    logic       rdy_a = 1'b0, rdy_b = 1'b0;
    logic       clr_a = 1'b0, clr_b = 1'b0;
    logic [7:0] data_a, data_b;
    logic       val_a, val_b, line_a, line_b;
    logic [2:0] lvl_a;
    logic [4:0] lvl_b;
    logic       perr_a, perr_b, ferr_a, ferr_b, ovf_a, ovf_b, busy_a, busy_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 sys_clk = ~sys_clk;

    uart_line_rx #(
        .CLK_FREQ_HZ(1_600_000), .BAUDRATE(100_000), .DATA_BITS(8),
        .PARITY(PAR_EVEN), .STOP_BITS(1), .FIFO_DEPTH(4), .EOL_CHAR(8'h0A)
    ) dut_a (
        .sys_clk(sys_clk), .sys_rst(rst_a), .uart_rxd(rxd_a),
        .m_data(data_a), .m_valid(val_a), .m_ready(rdy_a),
        .line_avail(line_a), .fifo_level(lvl_a),
        .parity_err(perr_a), .frame_err(ferr_a), .overflow(ovf_a),
        .clr_err(clr_a), .rx_busy(busy_a)
    );

    uart_line_rx #(
        .CLK_FREQ_HZ(1_600_000), .BAUDRATE(100_000), .DATA_BITS(7),
        .PARITY(PAR_ODD), .STOP_BITS(2), .FIFO_DEPTH(16), .EOL_CHAR(8'h0A)
    ) dut_b (
        .sys_clk(sys_clk), .sys_rst(rst_b), .uart_rxd(rxd_b),
        .m_data(data_b), .m_valid(val_b), .m_ready(rdy_b),
        .line_avail(line_b), .fifo_level(lvl_b),
        .parity_err(perr_b), .frame_err(ferr_b), .overflow(ovf_b),
        .clr_err(clr_b), .rx_busy(busy_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] f_lvl(input int w);
        return (w == 0) ? 32'(lvl_a) : 32'(lvl_b);
    endfunction
    function automatic logic [31:0] f_data(input int w);
        return (w == 0) ? 32'(data_a) : 32'(data_b);
    endfunction
    function automatic logic [31:0] f_perr(input int w);
        return (w == 0) ? 32'(perr_a) : 32'(perr_b);
    endfunction
    function automatic logic [31:0] f_ferr(input int w);
        return (w == 0) ? 32'(ferr_a) : 32'(ferr_b);
    endfunction
    function automatic logic [31:0] f_line(input int w);
        return (w == 0) ? 32'(line_a) : 32'(line_b);
    endfunction

    // One bit time on the selected line; entered and left on a negedge.
    task automatic drive_bit(input int w, input logic b);
        if (w == 0) rxd_a = b; else rxd_b = b;
        repeat (DIV) @(negedge sys_clk);
    endtask

    // Full frame plus one idle bit. bad[i] forces stop bit i low.
    task automatic send_frame(input int w, input logic [7:0] d, input bit flip, input logic [1:0] bad);
        int nb, ns;
        bit odd;
        logic [7:0] dm;
        logic pb;
        nb  = (w == 0) ? 8 : 7;
        ns  = (w == 0) ? 1 : 2;
        odd = (w == 1);
        dm  = d & ((w == 0) ? 8'hFF : 8'h7F);
        pb  = odd ? ($countones(dm) % 2 == 0) : ($countones(dm) % 2 == 1);
        @(negedge sys_clk);
        drive_bit(w, 1'b0);
        for (int i = 0; i < nb; i++) drive_bit(w, dm[i]);
        drive_bit(w, pb ^ flip);
        for (int i = 0; i < ns; i++) drive_bit(w, ~bad[i]);
        drive_bit(w, 1'b1);
    endtask

    // Pop one entry; called and returns on a negedge.
    task automatic pop(input int w, output logic [7:0] d);
        d = 8'(f_data(w));
        if (w == 0) rdy_a = 1'b1; else rdy_b = 1'b1;
        @(negedge sys_clk);
        rdy_a = 1'b0;
        rdy_b = 1'b0;
    endtask

    task automatic pulse_clr(input int w);
        if (w == 0) clr_a = 1'b1; else clr_b = 1'b1;
        @(negedge sys_clk);
        clr_a = 1'b0;
        clr_b = 1'b0;
    endtask

    typedef struct {
        logic [7:0] d;
        bit         flip;
        bit         bad;
        bit         hold_clr;
        bit         exp_push;
        bit         exp_perr;
        bit         exp_ferr;
        bit         exp_line;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded its time bound");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] got, d;
        logic [7:0] q [$];
        logic [1:0] bad;
        bit flip, eperr, eferr, sbad, has_eol;

        tbl[0] = '{8'h41, 0, 0, 0, 1, 0, 0, 0};
        tbl[1] = '{8'h41, 1, 0, 0, 0, 1, 0, 0};
        tbl[2] = '{8'h55, 0, 1, 0, 0, 0, 1, 0};
        tbl[3] = '{8'h0A, 0, 0, 0, 1, 0, 0, 1};
        tbl[4] = '{8'h00, 0, 0, 0, 1, 0, 0, 0};
        tbl[5] = '{8'hFF, 0, 0, 0, 1, 0, 0, 0};
        tbl[6] = '{8'hC3, 1, 1, 0, 0, 1, 1, 0};
        tbl[7] = '{8'h41, 1, 0, 1, 0, 0, 0, 0};

        // Reset state
        repeat (3) @(negedge sys_clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        chk("rst_valid_a", val_a, 0);
        chk("rst_level_a", lvl_a, 0);
        chk("rst_line_a", line_a, 0);
        chk("rst_flags_a", {perr_a, ferr_a, ovf_a}, 0);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_valid_b", val_b, 0);
        chk("rst_flags_b", {perr_b, ferr_b, ovf_b, busy_b}, 0);
        repeat (DIV) @(negedge sys_clk);

        // Good frame latency: first edge sampling the start bit is t0
        fork
            send_frame(0, 8'h41, 0, 2'b00);
            begin
                @(negedge sys_clk);
                @(posedge sys_clk);
                repeat (170) @(posedge sys_clk);
                #1 chk("lat_valid_early", val_a, 0);
                @(posedge sys_clk);
                #1 chk("lat_valid_171", val_a, 1);
            end
        join
        chk("good_data", data_a, 8'h41);
        chk("good_perr", perr_a, 0);
        pop(0, got);
        chk("good_drained", lvl_a, 0);

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            clr_a = tbl[i].hold_clr;
            send_frame(0, tbl[i].d, tbl[i].flip, {1'b0, tbl[i].bad});
            clr_a = 1'b0;
            chk("tbl_level", lvl_a, 32'(tbl[i].exp_push));
            chk("tbl_perr", perr_a, 32'(tbl[i].exp_perr));
            chk("tbl_ferr", ferr_a, 32'(tbl[i].exp_ferr));
            chk("tbl_line", line_a, 32'(tbl[i].exp_line));
            if (tbl[i].exp_push) chk("tbl_data", data_a, 32'(tbl[i].d));
            pulse_clr(0);
            chk("tbl_clr", {perr_a, ferr_a, ovf_a}, 0);
            pop(0, got);
            chk("tbl_empty", lvl_a, 0);
            chk("tbl_line_pop", line_a, 0);
        end

        // False start: 4-cycle glitch
        fork
            begin
                @(negedge sys_clk);
                rxd_a = 1'b0;
                repeat (4) @(negedge sys_clk);
                rxd_a = 1'b1;
            end
            begin
                @(negedge sys_clk);
                @(posedge sys_clk);
                @(posedge sys_clk);
                #1 chk("glitch_busy_t1", busy_a, 0);
                @(posedge sys_clk);
                #1 chk("glitch_busy_t2", busy_a, 1);
                repeat (7) @(posedge sys_clk);
                #1 chk("glitch_busy_t9", busy_a, 1);
                @(posedge sys_clk);
                #1 chk("glitch_busy_t10", busy_a, 0);
            end
        join
        repeat (3 * DIV) @(negedge sys_clk);
        chk("glitch_level", lvl_a, 0);
        chk("glitch_flags", {perr_a, ferr_a}, 0);

        // Overflow with a 4-deep FIFO
        for (int i = 0; i < 5; i++) send_frame(0, 8'h11 + 8'(i), 0, 2'b00);
        chk("ovf_level", lvl_a, 4);
        chk("ovf_flag", ovf_a, 1);
        chk("ovf_head", data_a, 8'h11);
        pulse_clr(0);
        chk("ovf_clr", ovf_a, 0);
        fork
            send_frame(0, 8'h16, 0, 2'b00);
            begin
                @(negedge sys_clk);
                @(posedge sys_clk);
                repeat (170) @(posedge sys_clk);
                @(negedge sys_clk);
                rdy_a = 1'b1;
                @(negedge sys_clk);
                rdy_a = 1'b0;
            end
        join
        chk("full_pp_level", lvl_a, 4);
        chk("full_pp_ovf", ovf_a, 0);
        chk("full_pp_head", data_a, 8'h12);
        pop(0, got); chk("full_pp_d0", got, 8'h12);
        pop(0, got); chk("full_pp_d1", got, 8'h13);
        pop(0, got); chk("full_pp_d2", got, 8'h14);
        pop(0, got); chk("full_pp_d3", got, 8'h16);

        // Line tracking: "OK\n" then "A"
        send_frame(0, 8'h4F, 0, 2'b00);
        send_frame(0, 8'h4B, 0, 2'b00);
        chk("line_before_eol", line_a, 0);
        send_frame(0, 8'h0A, 0, 2'b00);
        chk("line_after_eol", line_a, 1);
        send_frame(0, 8'h41, 0, 2'b00);
        chk("line_level4", lvl_a, 4);
        pop(0, got); chk("line_pop_O", got, 8'h4F);
        pop(0, got); chk("line_pop_K", got, 8'h4B);
        chk("line_still", line_a, 1);
        pop(0, got); chk("line_pop_nl", got, 8'h0A);
        chk("line_gone", line_a, 0);
        chk("line_level1", lvl_a, 1);
        pop(0, got);

        // 7O2 frame, then reset during DATA of the next frame
        send_frame(1, 8'h3F, 0, 2'b00);
        chk("mode_data", data_b, 8'h3F);
        chk("mode_level", lvl_b, 1);
        chk("mode_flags", {perr_b, ferr_b}, 0);
        fork
            send_frame(1, 8'h78, 0, 2'b00);
            begin
                @(negedge sys_clk);
                repeat (5 * DIV + 5) @(negedge sys_clk);
                chk("mid_busy", busy_b, 1);
                rst_b = 1'b1;
                repeat (2) @(negedge sys_clk);
                rst_b = 1'b0;
                chk("mid_rst_valid", val_b, 0);
                chk("mid_rst_level", lvl_b, 0);
                chk("mid_rst_busy", busy_b, 0);
                chk("mid_rst_flags", {perr_b, ferr_b, ovf_b, line_b}, 0);
            end
        join
        repeat (2 * DIV) @(negedge sys_clk);
        chk("post_rst_level", lvl_b, 0);
        send_frame(1, 8'h55, 0, 2'b00);
        chk("post_rst_data", data_b, 8'h55);
        chk("post_rst_lvl", lvl_b, 1);
        chk("post_rst_flags", {perr_b, ferr_b}, 0);
        pop(1, got);

        // Randomized frames against a queue model
        for (int w = 0; w < 2; w++) begin
            pulse_clr(w);
            q.delete();
            eperr = 0;
            eferr = 0;
            for (int n = 0; n < 24; n++) begin
                d = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 3) == 0) d = 8'h0A;
                if (w == 1) d = d & 8'h7F;
                flip = ($urandom_range(0, 4) == 0);
                bad[0] = ($urandom_range(0, 4) == 0);
                bad[1] = (w == 1) && ($urandom_range(0, 4) == 0);
                sbad = bad[0] | bad[1];
                send_frame(w, d, flip, bad);
                if (!flip && !sbad) q.push_back(d);
                eperr |= flip;
                eferr |= sbad;
                has_eol = 0;
                foreach (q[k]) if (q[k] == 8'h0A) has_eol = 1;
                chk("rnd_level", f_lvl(w), q.size());
                chk("rnd_perr", f_perr(w), 32'(eperr));
                chk("rnd_ferr", f_ferr(w), 32'(eferr));
                chk("rnd_line", f_line(w), 32'(has_eol));
                if (q.size() > 0) chk("rnd_head", f_data(w), 32'(q[0]));
                if (q.size() >= 3 || $urandom_range(0, 2) == 0) begin
                    while (q.size() > 0) begin
                        pop(w, got);
                        chk("rnd_data", got, 32'(q.pop_front()));
                    end
                    chk("rnd_drained", f_lvl(w), 0);
                end
                if ($urandom_range(0, 3) == 0) begin
                    pulse_clr(w);
                    eperr = 0;
                    eferr = 0;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
